pmod_frame_router: RTL
======================

// Module: pmod_frame_router
// PURPOSE
//  Aligns sample frames from N_PMODS eurorack-pmod codec instances and routes them to outputs.
//  Each instance strobes independently; the block gathers one frame from every instance, then
//  routes any input channel to any output channel with optional inversion.
//  The result is emitted as one aligned multi-channel frame.
//  Sits between the pmod instances and the DSP core in the top level.
// PARAMETERS
//  W        16   sample width, bits, signed two's complement
//  N_PMODS  2    number of pmod instances aggregated
//  N_CH     4    channels per pmod
//  TIMEOUT  512  cycles allowed after the first strobe before the frame is forced out
//  (derived) T = N_PMODS*N_CH total channels; SW = $clog2(T+1) select width
// PORTS
//  clk_12mhz          in   1          system clock
//  rst_n              in   1          synchronous reset, active low
//  sample_strobe_in   in   N_PMODS    1-cycle pulse per pmod; its slice of sample_in is valid that cycle
//  sample_in          in   T*W        channel c of pmod p at index p*N_CH+c
//  route_sel          in   T*SW       per output k: source channel index; value >= T routes zero
//  route_inv          in   T          per output k: negate the routed sample
//  err_clr            in   1          clears err_timeout and drop_count
//  sample_out         out  T*W        aligned, routed frame
//  sample_strobe_out  out  1          1-cycle pulse when sample_out updates
//  err_timeout        out  1          sticky; a frame was forced out by timeout
//  drop_count         out  8          saturating count of strobes dropped during ROUTE/EMIT
// BEHAVIOUR
//  Reset (rst_n=0 at clock edge): state=IDLE; frame buffer, sample_out, pending, timer and
//    drop_count are zero; sample_strobe_out=0; err_timeout=0.
//  FSM states: IDLE, COLLECT, ROUTE, EMIT.
//  IDLE:
//    - Any strobe captures those pmods' slices and sets their pending bits.
//    - Timer is set to 0; next state is COLLECT. If all pending bits are set, next state is ROUTE.
//  COLLECT:
//    - Timer increments every cycle.
//    - A strobe from a pmod that is already pending overwrites its slice; the newest sample wins.
//    - All pending bits set -> ROUTE.
//    - Timer == TIMEOUT-1 -> ROUTE with err_timeout<=1. Missing pmods keep the previous frame's values.
//  Entering ROUTE:
//    - route_sel and route_inv are snapshotted, so changes during routing cannot tear a frame.
//    - pending is cleared.
//  ROUTE:
//    - Processes one output per cycle, k = 0..T-1. Takes T cycles.
//    - out_k = buf[sel_k], or 0 if sel_k >= T.
//    - If inv_k is set, out_k is negated with saturation: -(-2^(W-1)) = 2^(W-1)-1.
//  EMIT:
//    - sample_out <= routed buffer and sample_strobe_out=1 for exactly this one cycle.
//    - Next state is IDLE.
//  Latency: the strobe that completes the frame at cycle t gives sample_strobe_out at cycle t+T+1.
//  Strobes arriving in ROUTE or EMIT are dropped; drop_count increments and saturates at 255.
//  err_clr has priority over a same-cycle error set: both are cleared, and the new event is lost.
//  sample_out holds its value between EMITs.
//  rst_n low mid-frame aborts the frame with no strobe and returns all outputs to their reset values.
// CONFIGURATION
//  ROUTER_MIX_EN defined:
//    - Adds ports route_sel_b (in, T*SW) and route_mix (in, T), both snapshotted with route_sel.
//    - If route_mix[k]=1: out_k = sat(a_k + buf[sel_b_k]), where a_k is the routed and optionally
//      inverted sample. Addition is done at W+1 bits and clamped to [-2^(W-1), 2^(W-1)-1].
//    - Same ROUTE cycle count and latency as without the macro.
//  ROUTER_MIX_EN undefined:
//    - The extra ports and the adder are absent; behaviour is single-source only as above.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles mid-COLLECT.
//      -> all outputs 0; no sample_strobe_out for 600 cycles without strobes.
//  2 Identity route, W=16, N_PMODS=2, N_CH=4; both strobes at t; sample_in[i]=100*i.
//      -> sample_out[i]=100*i; sample_strobe_out at t+9 only.
//  3 Skew: pmod0 strobes at t, pmod1 at t+37.
//      -> single sample_strobe_out at t+46; err_timeout=0.
//  4 Timeout, TIMEOUT=64: only pmod0 strobes, at t.
//      -> strobe at t+72; pmod1 outputs hold the previous frame; err_timeout=1; err_clr -> 0.
//  5 Edges: sample -32768 with inv=1 -> 32767; route_sel=8 -> 0; a strobe during ROUTE -> drop_count=1.
//  6 ROUTER_MIX_EN: a=30000, b=10000 -> 32767; a=-30000, b=-10000 -> -32768; a=5, b=-7 -> -2.

Source files
------------

// File: rtl/pmod_frame_router.sv
// rtl/pmod_frame_router.sv - aligns per-pmod sample frames, routes/inverts channels, emits one frame.
// Optional ROUTER_MIX_EN adds a second source per output with a saturating mix.
module pmod_frame_router #(
  parameter int W       = 16,
  parameter int N_PMODS = 2,
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 512
) (
  input  logic                                      clk_12mhz,
  input  logic                                      rst_n,
  input  logic [N_PMODS-1:0]                        sample_strobe_in,
  input  logic [N_PMODS*N_CH*W-1:0]                 sample_in,
  input  logic [N_PMODS*N_CH*$clog2(N_PMODS*N_CH+1)-1:0] route_sel,
  input  logic [N_PMODS*N_CH-1:0]                   route_inv,
`ifdef ROUTER_MIX_EN
  input  logic [N_PMODS*N_CH*$clog2(N_PMODS*N_CH+1)-1:0] route_sel_b,
  input  logic [N_PMODS*N_CH-1:0]                   route_mix,
`endif
  input  logic                                      err_clr,
  output logic [N_PMODS*N_CH*W-1:0]                 sample_out,
  output logic                                      sample_strobe_out,
  output logic                                      err_timeout,
  output logic [7:0]                                drop_count
);
  localparam int T  = N_PMODS * N_CH;
  localparam int SW = $clog2(T + 1);
  localparam int KW = (T > 1) ? $clog2(T) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] S_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] S_MAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ROUTE, S_EMIT} state_t;
  state_t r_state, w_state_next;

  logic [N_PMODS-1:0] r_pending;
  logic [TW-1:0]      r_timer;
  logic [T*W-1:0]     r_buf, r_rbuf, r_sample_out;
  logic [T*SW-1:0]    r_sel;
  logic [T-1:0]       r_inv;
  logic [KW-1:0]      r_k;
  logic               r_err;
  logic [7:0]         r_drop;

  logic           w_all, w_timeout, w_enter_route, w_inv;
  logic [TW-1:0]  w_tnext;
  logic [SW-1:0]  w_sel;
  logic [W-1:0]   w_src, w_a, w_out;
  logic [T*W-1:0] w_rbuf_next;
  logic [8:0]     w_ndrop;

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    w_all        = &(r_pending | sample_strobe_in);
    w_tnext      = r_timer + 1'b1;
    case (r_state)
      S_IDLE:
        if (|sample_strobe_in) w_state_next = w_all ? S_ROUTE : S_COLLECT;
      S_COLLECT:
        if (w_all) begin
          w_state_next = S_ROUTE;
        end else if (w_tnext == TW'(TIMEOUT - 1)) begin
          w_state_next = S_ROUTE;
          w_timeout    = 1'b1;
        end
      S_ROUTE:
        if (r_k == KW'(T - 1)) w_state_next = S_EMIT;
      default:
        w_state_next = S_IDLE;
    endcase
    w_enter_route = (r_state != S_ROUTE) && (w_state_next == S_ROUTE);
  end

`ifdef ROUTER_MIX_EN
  logic [T*SW-1:0] r_sel_b;
  logic [T-1:0]    r_mix;
  logic [SW-1:0]   w_sel_b;
  logic [W-1:0]    w_b;
  logic            w_mix;
  logic [W:0]      w_sum;
`endif

  // Datapath for the single output k currently being routed.
  always_comb begin
    w_sel = '0;
    w_inv = 1'b0;
    w_src = '0;
    for (int i = 0; i < T; i++)
      if (r_k == KW'(i)) begin
        w_sel = r_sel[i*SW +: SW];
        w_inv = r_inv[i];
      end
    for (int i = 0; i < T; i++)
      if (w_sel == SW'(i)) w_src = r_buf[i*W +: W];
    if (w_inv) w_a = (w_src == S_MIN) ? S_MAX : (~w_src + 1'b1);
    else       w_a = w_src;
    w_out = w_a;
`ifdef ROUTER_MIX_EN
    w_sel_b = '0;
    w_mix   = 1'b0;
    w_b     = '0;
    for (int i = 0; i < T; i++)
      if (r_k == KW'(i)) begin
        w_sel_b = r_sel_b[i*SW +: SW];
        w_mix   = r_mix[i];
      end
    for (int i = 0; i < T; i++)
      if (w_sel_b == SW'(i)) w_b = r_buf[i*W +: W];
    w_sum = {w_a[W-1], w_a} + {w_b[W-1], w_b};
    if (w_mix) begin
      if (w_sum[W] != w_sum[W-1]) w_out = w_sum[W] ? S_MIN : S_MAX;
      else                        w_out = w_sum[W-1:0];
    end
`endif
    w_rbuf_next = r_rbuf;
    for (int i = 0; i < T; i++)
      if (r_k == KW'(i)) w_rbuf_next[i*W +: W] = w_out;
    w_ndrop = {1'b0, r_drop};
    for (int p = 0; p < N_PMODS; p++)
      w_ndrop = w_ndrop + 9'(sample_strobe_in[p]);
  end

  always_ff @(posedge clk_12mhz) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pending    <= '0;
      r_timer      <= '0;
      r_buf        <= '0;
      r_rbuf       <= '0;
      r_sample_out <= '0;
      r_sel        <= '0;
      r_inv        <= '0;
      r_k          <= '0;
      r_err        <= 1'b0;
      r_drop       <= '0;
`ifdef ROUTER_MIX_EN
      r_sel_b      <= '0;
      r_mix        <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE || r_state == S_COLLECT) begin
        for (int p = 0; p < N_PMODS; p++)
          if (sample_strobe_in[p]) r_buf[p*N_CH*W +: N_CH*W] <= sample_in[p*N_CH*W +: N_CH*W];
        r_pending <= r_pending | sample_strobe_in;
        r_timer   <= (r_state == S_IDLE) ? '0 : w_tnext;
      end
      // Snapshot routing controls so mid-route changes cannot tear a frame.
      if (w_enter_route) begin
        r_sel     <= route_sel;
        r_inv     <= route_inv;
`ifdef ROUTER_MIX_EN
        r_sel_b   <= route_sel_b;
        r_mix     <= route_mix;
`endif
        r_pending <= '0;
        r_k       <= '0;
      end
      if (r_state == S_ROUTE) begin
        r_rbuf <= w_rbuf_next;
        r_k    <= r_k + 1'b1;
        if (r_k == KW'(T - 1)) r_sample_out <= w_rbuf_next;
      end
      if (err_clr)        r_err <= 1'b0;
      else if (w_timeout) r_err <= 1'b1;
      if (err_clr)
        r_drop <= '0;
      else if ((r_state == S_ROUTE || r_state == S_EMIT) && |sample_strobe_in)
        r_drop <= w_ndrop[8] ? 8'hFF : w_ndrop[7:0];
    end
  end

  assign sample_out        = r_sample_out;
  assign sample_strobe_out = (r_state == S_EMIT);
  assign err_timeout       = r_err;
  assign drop_count        = r_drop;
endmodule
